// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment controller: latches a value as hex or as BCD
// (sequential double-dabble), then scans DIGITS digits at a prescaled rate.
module seg_scan_display #(
  parameter int DIGITS     = 4,
  parameter int DATA_W     = 12,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic              dec_mode,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              done
);
  // BCD digits covering the whole DATA_W range, never fewer than DIGITS
  localparam int   BCD_MIN = (DATA_W + 2) / 3;
  localparam int   BCD_N   = (BCD_MIN > DIGITS) ? BCD_MIN : DIGITS;
  localparam int   SRW     = 4 * BCD_N + DATA_W;
  localparam int   CW      = $clog2(DATA_W + 1);
  localparam int   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int   IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL     = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {S_IDLE, S_CAP, S_CONV} state_t;

  state_t                 r_state;
  logic                   r_dec;
  logic [SRW-1:0]         r_sr;
  logic [CW-1:0]          r_cnt;
  logic [DIGITS-1:0][3:0] r_disp;
  logic                   r_ovf;
  logic                   r_busy;
  logic                   r_done;
  logic [PW-1:0]          r_pre;
  logic [IW-1:0]          r_idx;
  logic [DIGITS-1:0]      r_an;
  logic [6:0]             r_seg;

  logic [SRW-1:0]         w_adj;
  logic [SRW-1:0]         w_sr_nx;
  logic [DIGITS-1:0][3:0] w_hex;
  logic [DIGITS-1:0][3:0] w_bcd_lo;
  logic                   w_ovf;
  logic                   w_tick;
  logic [IW-1:0]          w_idx_nx;
  logic [DIGITS-1:0]      w_uz;
  logic [DIGITS-1:0][6:0] w_pat;
  logic [6:0]             w_seg_sel;
  logic [DIGITS-1:0]      w_an_sel;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // one double-dabble iteration: adjust every BCD digit, then shift the lot
  always_comb begin
    w_adj = r_sr;
    for (int k = 0; k < BCD_N; k++)
      if (r_sr[DATA_W+4*k +: 4] >= 4'd5)
        w_adj[DATA_W+4*k +: 4] = r_sr[DATA_W+4*k +: 4] + 4'd3;
    w_sr_nx = {w_adj[SRW-2:0], 1'b0};
  end

  always_comb begin
    w_ovf = 1'b0;
    for (int k = DIGITS; k < BCD_N; k++)
      w_ovf = w_ovf | (|r_sr[DATA_W+4*k +: 4]);
  end

  assign w_hex    = (4*DIGITS)'(r_sr[DATA_W-1:0]);
  assign w_bcd_lo = r_sr[DATA_W +: 4*DIGITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dec   <= 1'b0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (load) begin
          r_sr    <= SRW'(value);
          r_dec   <= dec_mode;
          r_state <= S_CAP;
        end
        S_CAP: if (!r_dec) begin
          r_disp  <= w_hex;
          r_ovf   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_sr    <= w_sr_nx;
          r_cnt   <= CW'(1);
          r_busy  <= 1'b1;
          r_state <= S_CONV;
        end
        S_CONV: if (r_cnt == CW'(DATA_W)) begin
          r_disp  <= w_bcd_lo;
          r_ovf   <= w_ovf;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_sr  <= w_sr_nx;
          r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_tick   = (r_pre == PW'(PRESCALE - 1));
  assign w_idx_nx = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign w_uz[d]  = ~|r_disp[DIGITS-1:d];
    assign w_pat[d] = r_ovf                        ? 7'h40 :
                      (blank_lz && d > 0 && w_uz[d]) ? 7'h00 : hex7(r_disp[d]);
  end

  always_comb begin
    w_seg_sel = '0;
    w_an_sel  = '0;
    for (int d = 0; d < DIGITS; d++)
      if (w_idx_nx == IW'(d)) begin
        w_seg_sel   = w_pat[d];
        w_an_sel[d] = 1'b1;
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= {DIGITS{POL}};
      r_seg <= {7{POL}};
    end else if (w_tick) begin
      r_pre <= '0;
      r_idx <= w_idx_nx;
      r_an  <= w_an_sel ^ {DIGITS{POL}};
      r_seg <= w_seg_sel ^ {7{POL}};
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign dp   = POL;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench: a 4-digit and a 3-digit instance share stimulus; expected
// digit patterns come from a decimal/hex arithmetic model of the display.
module tb_seg_scan_display;
  localparam int DW = 12;
  localparam int PS = 2;

  logic          clk = 1'b0, rst = 1'b1, load = 1'b0, dec_mode = 1'b0, blank_lz = 1'b0;
  logic [DW-1:0] value = '0;
  logic [6:0]    seg4, seg3;
  logic          dp4, dp3, busy4, busy3, done4, done3;
  logic [3:0]    an4;
  logic [2:0]    an3;

  always #5 clk = ~clk;

  seg_scan_display #(.DIGITS(4), .DATA_W(DW), .PRESCALE(PS), .ACTIVE_LOW(1)) u_dut4 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .seg(seg4), .dp(dp4), .an(an4), .busy(busy4), .done(done4));

  seg_scan_display #(.DIGITS(3), .DATA_W(DW), .PRESCALE(PS), .ACTIVE_LOW(1)) u_dut3 (
    .clk(clk), .rst(rst), .value(value), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .seg(seg3), .dp(dp3), .an(an3), .busy(busy3), .done(done3));

  typedef struct {
    logic [3:0][6:0] e4;
    logic [2:0][6:0] e3;
    string           tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, mon_cnt = 0;
  int   n = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] lut(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // active-low pattern that digit d of an nd-digit display should show
  function automatic logic [6:0] model_seg(input int v, input bit dec, input bit blz,
                                           input int nd, input int d);
    int dig[8];
    int p;
    bit allz;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      dig[i] = dec ? (v / p) % 10 : (v >> (4 * i)) & 15;
      p = p * 10;
    end
    if (dec && v >= p) return 7'h3F;
    allz = 1'b1;
    for (int j = d; j < nd; j++) if (dig[j] != 0) allz = 1'b0;
    if (blz && d > 0 && allz) return 7'h7F;
    return ~lut(dig[d]);
  endfunction

  task automatic capture(output logic [3:0][6:0] g4, output logic [2:0][6:0] g3);
    g4 = 'x;
    g3 = 'x;
    repeat (16) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) if (an4 == ~(4'b0001 << d)) g4[d] = seg4;
      for (int d = 0; d < 3; d++) if (an3 == ~(3'b001 << d)) g3[d] = seg3;
    end
  endtask

  // edges since the last reset edge, used by the scan-order model
  always @(posedge clk) n <= rst ? 0 : ((n < 0) ? n : n + 1);

  always @(negedge clk) begin
    if (n >= 0) begin
      if (n < PS) begin
        chk("an4_blank", an4, 4'hF);
        chk("an3_blank", an3, 3'h7);
        chk("seg4_blank", seg4, 7'h7F);
        chk("seg3_blank", seg3, 7'h7F);
      end else begin
        chk("an4_scan", an4, ~(64'd1 << ((n / PS) % 4)) & 64'hF);
        chk("an3_scan", an3, ~(64'd1 << ((n / PS) % 3)) & 64'h7);
      end
      chk("dp", {dp4, dp3}, 2'b11);
    end
  end

  // monitor: each done pops one expectation and checks what the scan shows
  initial begin
    logic [3:0][6:0] g4;
    logic [2:0][6:0] g3;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        chk("done3_sync", done3, 1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got 1 want 0");
        end else begin
          e = sb.pop_front();
          repeat (8) @(negedge clk);
          capture(g4, g3);
          for (int d = 0; d < 4; d++) chk($sformatf("%s_u4_d%0d", e.tag, d), g4[d], e.e4[d]);
          for (int d = 0; d < 3; d++) chk($sformatf("%s_u3_d%0d", e.tag, d), g3[d], e.e3[d]);
        end
        mon_cnt++;
      end
    end
  end

  task automatic do_load(input logic [DW-1:0] v, input bit dec, input bit blz,
                         input int inj, input string tag);
    exp_t e;
    int nb, nd, first, target;
    nb = 0; nd = 0; first = -1;
    for (int d = 0; d < 4; d++) e.e4[d] = model_seg(int'(v), dec, blz, 4, d);
    for (int d = 0; d < 3; d++) e.e3[d] = model_seg(int'(v), dec, blz, 3, d);
    e.tag = tag;
    sb.push_back(e);
    target = mon_cnt + 1;
    blank_lz = blz; value = v; dec_mode = dec; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 1; k <= DW + 10; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (busy4) nb++;
      if (done4) begin
        nd++;
        if (first < 0) first = k;
      end
      if (inj > 0 && busy4 && nb == inj) begin
        value = 12'h123; dec_mode = 1'b0; load = 1'b1;
      end
    end
    chk({tag, "_done_lat"}, first, dec ? DW + 1 : 1);
    chk({tag, "_busy_cycles"}, nb, dec ? DW : 0);
    chk({tag, "_done_count"}, nd, 1);
    for (int i = 0; i < 100 && mon_cnt < target; i++) @(negedge clk);
    chk({tag, "_monitor"}, mon_cnt >= target, 1);
  endtask

  initial begin
    logic [3:0][6:0] g4;
    logic [2:0][6:0] g3;
    int nb, nd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {busy4, busy3}, 2'b00);
    chk("rst_done", {done4, done3}, 2'b00);
    chk("rst_an4", an4, 4'hF);
    chk("rst_seg4", seg4, 7'h7F);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_load(12'hABC, 1'b0, 1'b0, 0, "hexABC");
    do_load(12'd4095, 1'b1, 1'b0, 0, "dec4095");
    do_load(12'd1000, 1'b1, 1'b0, 0, "dec1000");
    do_load(12'd7, 1'b1, 1'b1, 0, "dec7blz");
    do_load(12'd999, 1'b1, 1'b0, 5, "dec999ign");

    // reset in the middle of a conversion
    blank_lz = 1'b1; value = 12'd2345; dec_mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nb = 0;
    for (int k = 0; k < 40 && nb < 6; k++) begin
      @(negedge clk);
      if (busy4) nb++;
    end
    chk("midrst_busy_reached", nb, 6);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {busy4, busy3}, 2'b00);
    chk("midrst_done", {done4, done3}, 2'b00);
    rst = 1'b0;
    nd = 0;
    repeat (30) @(negedge clk) if (done4) nd++;
    chk("midrst_no_done", nd, 0);
    capture(g4, g3);
    for (int d = 0; d < 4; d++) chk($sformatf("midrst_u4_d%0d", d), g4[d], model_seg(0, 1'b0, 1'b1, 4, d));
    for (int d = 0; d < 3; d++) chk($sformatf("midrst_u3_d%0d", d), g3[d], model_seg(0, 1'b0, 1'b1, 3, d));
    do_load(12'd321, 1'b1, 1'b1, 0, "after_rst");

    for (int i = 0; i < 20; i++)
      do_load(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", i));

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
